// File: rtl/digit_serial_adder_if.sv
// Host-side bundle for digit_serial_adder: request, operands and result.
// The host drives through the master modport; the adder uses the slave modport.
interface digit_serial_adder_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             CarryIn;
    logic             Subtract;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             CarryOut;
    logic             Overflow;

    modport master (
        output Start, X, Y, CarryIn, Subtract,
        input  Busy, Done, Sum, CarryOut, Overflow
    );

    modport slave (
        input  Start, X, Y, CarryIn, Subtract,
        output Busy, Done, Sum, CarryOut, Overflow
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock, carry chained
// between digits in a register. Start/Busy/Done handshake; N = WIDTH/DIGIT
// cycles of latency after the accept edge.
// Optional feature: define DIGIT_SERIAL_ADDER_OVERFLOW_EN to build the signed
// overflow flag; otherwise Overflow is tied low.
module digit_serial_adder #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic                Clock,
    input  logic                ResetN,
    digit_serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N - 1);
    localparam logic [IDX_W-1:0] DIGIT_STEP = IDX_W'(DIGIT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             nextState_s;
    logic               accept_s;
    logic               lastDigit_s;

    logic [CNT_W-1:0]   counter_r;
    logic [WIDTH-1:0]   xOp_r;
    logic [WIDTH-1:0]   yOp_r;
    logic               carry_r;
    logic [WIDTH-1:0]   acc_r;

    logic [IDX_W-1:0]   digitBase_s;
    logic [DIGIT:0]     digitSum_s;
    logic [WIDTH-1:0]   accNext_s;

    logic [WIDTH-1:0]   sum_r;
    logic               carryOut_r;
    logic               busy_r;
    logic               done_r;

    // State register of the IDLE/RUN controller.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic: accept in IDLE, leave RUN after the final digit.
    always_comb begin
        nextState_s = state_r;
        accept_s    = 1'b0;
        lastDigit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    nextState_s = RUN;
                    accept_s    = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RUN: begin
                if (counter_r == LAST_CNT) begin
                    nextState_s = IDLE;
                    lastDigit_s = 1'b1;
                end else begin
                    nextState_s = RUN;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // One digit of the ripple: current digit slice plus the chained carry.
    always_comb begin
        digitBase_s = IDX_W'(counter_r) * DIGIT_STEP;
        digitSum_s  = {1'b0, xOp_r[digitBase_s +: DIGIT]}
                    + {1'b0, yOp_r[digitBase_s +: DIGIT]}
                    + {{DIGIT{1'b0}}, carry_r};
        accNext_s   = acc_r;
        accNext_s[digitBase_s +: DIGIT] = digitSum_s[DIGIT-1:0];
    end

    // Operand capture, digit iteration and result/handshake registers.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            counter_r  <= {CNT_W{1'b0}};
            xOp_r      <= {WIDTH{1'b0}};
            yOp_r      <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            acc_r      <= {WIDTH{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            carryOut_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (nextState_s == RUN);
            done_r <= lastDigit_s;
            if (accept_s) begin
                // Subtraction is X + ~Y + ~CarryIn, so invert Y and the carry here.
                xOp_r     <= bus.X;
                yOp_r     <= bus.Subtract ? ~bus.Y : bus.Y;
                carry_r   <= bus.CarryIn ^ bus.Subtract;
                counter_r <= {CNT_W{1'b0}};
                acc_r     <= {WIDTH{1'b0}};
            end else if (state_r == RUN) begin
                carry_r   <= digitSum_s[DIGIT];
                acc_r     <= accNext_s;
                counter_r <= lastDigit_s ? {CNT_W{1'b0}} : (counter_r + CNT_W'(1));
                if (lastDigit_s) begin
                    sum_r      <= accNext_s;
                    carryOut_r <= digitSum_s[DIGIT];
                end
            end
        end
    end

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    logic overflow_r;

    // Signed overflow, registered together with Sum on the final digit.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            overflow_r <= 1'b0;
        end else if ((state_r == RUN) && lastDigit_s) begin
            overflow_r <= (xOp_r[WIDTH-1] == yOp_r[WIDTH-1]) &&
                          (accNext_s[WIDTH-1] != xOp_r[WIDTH-1]);
        end
    end

    assign bus.Overflow = overflow_r;
`else
    assign bus.Overflow = 1'b0;
`endif

    assign bus.Sum      = sum_r;
    assign bus.CarryOut = carryOut_r;
    assign bus.Busy     = busy_r;
    assign bus.Done     = done_r;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomised self-checking bench for digit_serial_adder: a 64/8 instance for
// the main function plus 16/16 and 16/1 instances for the latency extremes.
// Expected results come from plain modular arithmetic on the operands.
module tb_digit_serial_adder;
    localparam int WIDTH = 64;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;

    digit_serial_adder_if #(.WIDTH(WIDTH)) bus();
    digit_serial_adder_if #(.WIDTH(16))    busWide();
    digit_serial_adder_if #(.WIDTH(16))    busNarrow();

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dutWide (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (busWide)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dutNarrow (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (busNarrow)
    );

    always #5 Clock = ~Clock;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [63:0] lastSum;
    logic [63:0] bx [3] = '{64'd1, 64'd3, 64'd10};
    logic [63:0] by [3] = '{64'd2, 64'd4, 64'd20};

    task automatic checkValue(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: w-bit add or subtract with carry/borrow, then signed overflow.
    function automatic void refModel(input int w, input logic [63:0] x, input logic [63:0] y,
                                     input logic cin, input logic sub,
                                     output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] mask;
        logic [64:0] xs;
        logic [64:0] ys;
        logic [64:0] full;
        mask = (65'd1 << w) - 65'd1;
        xs   = {1'b0, x} & mask;
        ys   = {1'b0, y} & mask;
        if (!sub) begin
            full = xs + ys + 65'(cin);
            co   = full[w];
        end else begin
            full = xs - ys - 65'(cin);
            co   = (xs >= ys + 65'(cin));
        end
        s = 64'(full & mask);
        if (!sub) begin
            ov = (xs[w-1] == ys[w-1]) && (s[w-1] != xs[w-1]);
        end else begin
            ov = (xs[w-1] != ys[w-1]) && (s[w-1] != xs[w-1]);
        end
`ifndef DIGIT_SERIAL_ADDER_OVERFLOW_EN
        ov = 1'b0;
`endif
    endfunction

    task automatic runOp(input logic [63:0] x, input logic [63:0] y, input logic cin,
                         input logic sub, input string tag);
        logic [63:0] es;
        logic        eco;
        logic        eov;
        int          cyc;
        bit          seen;
        refModel(64, x, y, cin, sub, es, eco, eov);
        bus.X = x; bus.Y = y; bus.CarryIn = cin; bus.Subtract = sub; bus.Start = 1'b1;
        @(posedge Clock); #1;
        // Operands are scrambled after acceptance; the result must not care.
        bus.Start    = 1'b0;
        bus.X        = {$urandom, $urandom};
        bus.Y        = {$urandom, $urandom};
        bus.CarryIn  = 1'($urandom_range(0, 1));
        bus.Subtract = 1'($urandom_range(0, 1));
        checkValue({tag, " busy after accept"}, bus.Busy, 1'b1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4 * N + 8) begin
            checkValue({tag, " sum held"}, bus.Sum, lastSum);
            @(posedge Clock); #1;
            cyc++;
            if (bus.Done) begin
                seen = 1'b1;
            end else begin
                bus.Start = 1'($urandom_range(0, 1));
            end
        end
        bus.Start = 1'b0;
        checkValue({tag, " done seen"}, seen, 1'b1);
        checkValue({tag, " latency"}, cyc, N);
        checkValue({tag, " busy at done"}, bus.Busy, 1'b0);
        checkValue({tag, " sum"}, bus.Sum, es);
        checkValue({tag, " carry"}, bus.CarryOut, eco);
        checkValue({tag, " overflow"}, bus.Overflow, eov);
        lastSum = es;
        @(posedge Clock); #1;
        checkValue({tag, " done one cycle"}, bus.Done, 1'b0);
    endtask

    task automatic runSmall(input logic [15:0] x, input logic [15:0] y, input logic cin,
                            input logic sub, input string tag);
        logic [63:0] es;
        logic        eco;
        logic        eov;
        int          cyc;
        int          latW;
        int          latN;
        logic [15:0] sW;
        logic [15:0] sN;
        logic        coW;
        logic        coN;
        refModel(16, {48'd0, x}, {48'd0, y}, cin, sub, es, eco, eov);
        busWide.X = x;   busWide.Y = y;   busWide.CarryIn = cin;   busWide.Subtract = sub;
        busNarrow.X = x; busNarrow.Y = y; busNarrow.CarryIn = cin; busNarrow.Subtract = sub;
        busWide.Start = 1'b1;
        busNarrow.Start = 1'b1;
        @(posedge Clock); #1;
        busWide.Start = 1'b0;
        busNarrow.Start = 1'b0;
        checkValue({tag, " n1 busy"}, busWide.Busy, 1'b1);
        cyc = 0; latW = 0; latN = 0;
        sW = 16'd0; sN = 16'd0; coW = 1'b0; coN = 1'b0;
        while ((latW == 0 || latN == 0) && cyc < 40) begin
            @(posedge Clock); #1;
            cyc++;
            if (busWide.Done && latW == 0) begin
                latW = cyc; sW = busWide.Sum; coW = busWide.CarryOut;
            end
            if (busNarrow.Done && latN == 0) begin
                latN = cyc; sN = busNarrow.Sum; coN = busNarrow.CarryOut;
            end
        end
        checkValue({tag, " n1 latency"}, latW, 1);
        checkValue({tag, " n1 sum"}, sW, es[15:0]);
        checkValue({tag, " n1 carry"}, coW, eco);
        checkValue({tag, " n16 latency"}, latN, 16);
        checkValue({tag, " n16 sum"}, sN, es[15:0]);
        checkValue({tag, " n16 carry"}, coN, eco);
        @(posedge Clock); #1;
    endtask

    initial begin
        int  idx;
        int  cyc;
        int  guard;
        bit  doneSeen;
        bus.Start = 1'b0; bus.X = 64'd0; bus.Y = 64'd0; bus.CarryIn = 1'b0; bus.Subtract = 1'b0;
        busWide.Start = 1'b0; busWide.X = 16'd0; busWide.Y = 16'd0;
        busWide.CarryIn = 1'b0; busWide.Subtract = 1'b0;
        busNarrow.Start = 1'b0; busNarrow.X = 16'd0; busNarrow.Y = 16'd0;
        busNarrow.CarryIn = 1'b0; busNarrow.Subtract = 1'b0;
        lastSum = 64'd0;

        ResetN = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checkValue("reset busy", bus.Busy, 1'b0);
        checkValue("reset done", bus.Done, 1'b0);
        checkValue("reset sum", bus.Sum, 64'd0);
        checkValue("reset carry", bus.CarryOut, 1'b0);
        checkValue("reset overflow", bus.Overflow, 1'b0);
        ResetN = 1'b1;
        @(posedge Clock); #1;

        runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "allones+1");
        runOp(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "maxpos+1");
        runOp(64'd5, 64'd7, 1'b0, 1'b1, "5-7");
        runOp(64'd7, 64'd5, 1'b1, 1'b1, "7-5-1");
        runOp(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, "minneg-1");

        // Start held high: one accept per completed operation.
        bus.X = bx[0]; bus.Y = by[0]; bus.CarryIn = 1'b0; bus.Subtract = 1'b0; bus.Start = 1'b1;
        @(posedge Clock); #1;
        idx = 0; cyc = 0; guard = 0;
        while (idx < 3 && guard < 100) begin
            @(posedge Clock); #1;
            cyc++;
            guard++;
            if (bus.Done) begin
                checkValue("b2b sum", bus.Sum, bx[idx] + by[idx]);
                checkValue("b2b period", cyc, N);
                idx++;
                cyc = -1;
                if (idx < 3) begin
                    bus.X = bx[idx];
                    bus.Y = by[idx];
                end else begin
                    bus.Start = 1'b0;
                end
            end
        end
        bus.Start = 1'b0;
        checkValue("b2b results", idx, 3);
        lastSum = 64'd30;
        @(posedge Clock); #1;

        // Reset during the fourth RUN cycle abandons the operation.
        bus.X = 64'h1234_5678_9ABC_DEF0; bus.Y = 64'h1111_1111_1111_1111;
        bus.CarryIn = 1'b0; bus.Subtract = 1'b0; bus.Start = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        repeat (3) begin
            @(posedge Clock); #1;
        end
        ResetN = 1'b0;
        @(posedge Clock); #1;
        checkValue("midreset busy", bus.Busy, 1'b0);
        checkValue("midreset done", bus.Done, 1'b0);
        checkValue("midreset sum", bus.Sum, 64'd0);
        checkValue("midreset carry", bus.CarryOut, 1'b0);
        ResetN = 1'b1;
        doneSeen = 1'b0;
        repeat (N + 4) begin
            @(posedge Clock); #1;
            if (bus.Done) doneSeen = 1'b1;
        end
        checkValue("midreset no done", doneSeen, 1'b0);
        lastSum = 64'd0;
        runOp(64'd100, 64'd23, 1'b1, 1'b0, "after reset");

        for (int i = 0; i < 20; i++) begin
            runOp({$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        runSmall(16'hABCD, 16'h1234, 1'b0, 1'b0, "abcd+1234");
        for (int i = 0; i < 5; i++) begin
            runSmall(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), "random16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
